// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - shared types and helpers for the quadrature decoder
package quad_decoder_pkg;

  typedef enum logic [1:0] {
    ST_FILL1 = 2'd0,
    ST_FILL2 = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam int FILTER_LEN_MIN = 1;
  localparam int FILTER_LEN_MAX = 15;

  // Next {B,A} Gray state in the forward direction: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] fwd_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_filter.sv
// rtl/quad_decoder_filter.sv - two-flop synchroniser plus stability filter for one phase
module quad_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  input  logic i_load,
  output logic o_sync,
  output logic o_f
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_f;
  logic [CNT_W-1:0] r_cnt;

  // Any return of s2 to f before acceptance restarts the run count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_f   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      if (i_load) begin
        r_f   <= r_s2;
        r_cnt <= '0;
      end else if (r_s2 == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_f   <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync = r_s2;
  assign o_f    = r_f;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature encoder front-end: filtering, Gray decode, inc/dec strobes
import quad_decoder_pkg::*;

module quad_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_q,
  input  logic       i_clr_err,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_err,
  output logic [1:0] o_phase
);

  state_t     r_state;
  logic [1:0] r_prev;
  logic       r_inc;
  logic       r_dec;
  logic       r_err;

  logic [1:0] w_sync;
  logic [1:0] w_f;
  logic       w_load;
  logic       w_step_err;

  assign w_load = (r_state == ST_LOAD);

  for (genvar i = 0; i < 2; i++) begin : g_phase
    quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk    (clk),
      .rst    (rst),
      .i_d    (i_q[i]),
      .i_load (w_load),
      .o_sync (w_sync[i]),
      .o_f    (w_f[i])
    );
  end

  assign w_step_err = (r_state == ST_RUN) && ((w_f ^ r_prev) == 2'b11);

  // Preload prev from the synchroniser so an encoder resting at non-00 is not an error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL1;
      r_prev  <= 2'b00;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_inc <= 1'b0;
      r_dec <= 1'b0;
      case (r_state)
        ST_FILL1: r_state <= ST_FILL2;
        ST_FILL2: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_prev  <= w_sync;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_f != r_prev) begin
            r_prev <= w_f;
            if (w_f == fwd_next(r_prev))
              r_inc <= 1'b1;
            else if (r_prev == fwd_next(w_f))
              r_dec <= 1'b1;
          end
        end
        default: r_state <= ST_FILL1;
      endcase
      if (w_step_err)
        r_err <= 1'b1;
      else if (i_clr_err)
        r_err <= 1'b0;
    end
  end

  assign o_inc   = r_inc;
  assign o_dec   = r_dec;
  assign o_err   = r_err;
  assign o_phase = w_f;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard testbench for quad_decoder
module tb_quad_decoder;

  localparam int FLEN = 3;
  localparam int LAT  = FLEN + 3;
  localparam logic [1:0] K_INC = 2'b10;
  localparam logic [1:0] K_DEC = 2'b01;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] q;
  logic       clr_err;
  logic       inc;
  logic       dec;
  logic       err;
  logic [1:0] phase;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t e;

  quad_decoder #(.FILTER_LEN(FLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_q       (q),
    .i_clr_err (clr_err),
    .o_inc     (inc),
    .o_dec     (dec),
    .o_err     (err),
    .o_phase   (phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      check("missed_strobe", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (inc || dec) begin
      check("inc_dec_excl", {31'd0, inc & dec}, 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, inc, dec}, 0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {30'd0, inc, dec}, {30'd0, e.kind});
        check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_strobe(input logic [1:0] kind);
    exp_t x;
    x.cyc  = cyc + LAT;
    x.kind = kind;
    sb.push_back(x);
  endtask

  task automatic step(input logic [1:0] v, input logic [1:0] kind);
    q = v;
    expect_strobe(kind);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    q       = 2'b11;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    check("rst_err", err, 0);
    check("rst_phase", phase, 0);

    rst = 1'b1;
    @(negedge clk); check("fill1_phase", phase, 0);
    @(negedge clk); check("fill2_phase", phase, 0);
    @(negedge clk); check("load_phase", phase, 2'b11);
    check("load_err", err, 0);
    repeat (4) @(negedge clk);

    step(2'b10, K_INC);
    step(2'b00, K_INC);
    step(2'b01, K_INC);
    step(2'b11, K_INC);
    step(2'b10, K_INC);
    step(2'b00, K_INC);
    check("fwd_err", err, 0);
    check("fwd_phase", phase, 2'b00);

    step(2'b10, K_DEC);
    step(2'b11, K_DEC);
    step(2'b01, K_DEC);
    step(2'b00, K_DEC);
    check("rev_err", err, 0);
    check("rev_phase", phase, 2'b00);

    q = 2'b01;
    repeat (2) @(negedge clk);
    q = 2'b00;
    repeat (8) @(negedge clk);
    check("glitch_phase", phase, 2'b00);

    q = 2'b01;
    expect_strobe(K_INC);
    repeat (3) @(negedge clk);
    q = 2'b00;
    expect_strobe(K_DEC);
    repeat (10) @(negedge clk);
    check("pulse3_phase", phase, 2'b00);
    check("pulse3_err", err, 0);

    q = 2'b11;
    repeat (8) @(negedge clk);
    check("jump_err", err, 1);
    check("jump_phase", phase, 2'b11);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_err", err, 0);

    q = 2'b00;
    repeat (LAT - 1) @(negedge clk);
    check("pre_jump2_err", err, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("clr_vs_new_err", err, 1);
    check("jump2_phase", phase, 2'b00);
    repeat (4) @(negedge clk);

    q = 2'b01;
    repeat (FLEN + 1) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_inc", inc, 0);
    check("midrst_dec", dec, 0);
    check("midrst_err", err, 0);
    check("midrst_phase", phase, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); check("rerun_fill1", phase, 0);
    @(negedge clk); check("rerun_fill2", phase, 0);
    @(negedge clk); check("rerun_load", phase, 2'b01);
    check("rerun_err", err, 0);
    repeat (10) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
